speed_selector: RTL and testbench

SPEED_SELECTOR -- requirements
Module: speed_selector

---
 rtl/speed_pkg.sv | 16 +
 rtl/button_debounce.sv | 61 ++++++
 rtl/speed_selector.sv | 68 ++++++
 tb/tb_speed_selector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared definitions for the LED blink speed selector: preset table and index type.
package speed_pkg;

  localparam int unsigned PRESET_COUNT = 4;
  localparam int unsigned PRESET_W     = 27;

  typedef logic [1:0] speed_idx_t;

  localparam logic [PRESET_W-1:0] PRESET [PRESET_COUNT] = '{
    27'd99_999_999,
    27'd49_999_999,
    27'd24_999_999,
    27'd12_499_999
  };

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability-window debouncer and single-cycle press pulse
// for one raw push-button input.
module button_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;

    // Any agreeing sample restarts the window; the level flips on the last differing cycle.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/speed_selector.sv
// Selects one of four blink-rate presets from debounced up/down button presses.
module speed_selector
  import speed_pkg::*;
#(
  parameter int unsigned N         = 27,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  output logic [N-1:0] speed_sel,
  output logic [1:0]   speed_idx,
  output logic         changed
);

  if (N < PRESET_W) begin : g_width_check
    $error("speed_selector: N must be at least 27 to hold the presets");
  end

  logic       up_press;
  logic       down_press;
  speed_idx_t idx_q, idx_d;
  logic [N-1:0] sel_q, sel_d;
  logic       changed_q, changed_d;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .press   (up_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_down (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_down),
    .press   (down_press)
  );

  always_comb begin
    idx_d = idx_q;
    if (up_press && !down_press && idx_q != 2'd3) begin
      idx_d = idx_q + 2'd1;
    end else if (down_press && !up_press && idx_q != 2'd0) begin
      idx_d = idx_q - 2'd1;
    end
    changed_d = (idx_d != idx_q);
    sel_d     = N'(PRESET[idx_d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      sel_q     <= N'(PRESET[0]);
      changed_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
    end
  end

  assign speed_idx = idx_q;
  assign speed_sel = sel_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_speed_selector.sv
// Self-checking bench for speed_selector with a short debounce window.
module tb_speed_selector;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [26:0] speed_sel;
  logic [1:0]  speed_idx;
  logic        changed;

  int errors = 0;
  int checks = 0;
  int chg_count = 0;
  bit chk_en = 1'b0;

  logic [26:0] exp_sel [4] = '{27'd99_999_999, 27'd49_999_999, 27'd24_999_999, 27'd12_499_999};

  always #5 clk = ~clk;

  speed_selector #(.N(27), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .speed_sel (speed_sel),
    .speed_idx (speed_idx),
    .changed   (changed)
  );

  // Reference model: each button is the raw input delayed two edges, a level that
  // flips once the last DB delayed samples all disagree with it, and a press on
  // the edge after the level rises.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_lvd [2];
  bit m_pulse [2];
  bit m_hist [2][DB];
  int m_idx = 0;
  bit m_chg = 1'b0;

  always @(posedge clk) begin : model
    bit raw [2];
    bit np [2];
    bit all_diff;
    int prev;
    raw[0] = btn_up;
    raw[1] = btn_down;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvd[b] = 0; m_pulse[b] = 0;
        for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
      end
      m_idx = 0;
      m_chg = 0;
    end else begin
      prev = m_idx;
      if (m_pulse[0] && !m_pulse[1]) m_idx = (m_idx < 3) ? m_idx + 1 : 3;
      else if (m_pulse[1] && !m_pulse[0]) m_idx = (m_idx > 0) ? m_idx - 1 : 0;
      m_chg = (m_idx != prev);
      for (int b = 0; b < 2; b++) begin
        np[b] = m_lvl[b] && !m_lvd[b];
        m_lvd[b] = m_lvl[b];
        for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
        if (all_diff) m_lvl[b] = !m_lvl[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
        m_pulse[b] = np[b];
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_idx", speed_idx, m_idx);
      chk("model_sel", speed_sel, exp_sel[m_idx]);
      chk("model_changed", changed, m_chg);
      if (changed) chg_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up, input bit dn);
    btn_up = up;
    btn_down = dn;
    step(12);
    btn_up = 0;
    btn_down = 0;
    step(12);
  endtask

  initial begin : stim
    int c0;
    int up_exp [5];
    int dn_exp [4];
    int len;
    up_exp = '{1, 2, 3, 3, 3};
    dn_exp = '{2, 1, 0, 0};

    step(1);
    chk_en = 1;
    step(2);
    chk("reset_idx", speed_idx, 0);
    chk("reset_sel", speed_sel, 99_999_999);
    chk("reset_changed", changed, 0);

    // Single held press: new index visible DB+4 edges after the button goes high.
    c0 = chg_count;
    rst = 0;
    btn_up = 1;
    step(7);
    chk("press_early_idx", speed_idx, 0);
    step(1);
    chk("press_idx", speed_idx, 1);
    chk("press_sel", speed_sel, 49_999_999);
    chk("press_changed", changed, 1);
    step(1);
    chk("press_changed_drop", changed, 0);
    step(20);
    chk("press_held_idx", speed_idx, 1);
    chk("press_held_changes", chg_count - c0, 1);
    btn_up = 0;
    step(12);

    // Glitch shorter than the window.
    c0 = chg_count;
    btn_up = 1;
    step(3);
    btn_up = 0;
    step(15);
    chk("glitch_idx", speed_idx, 1);
    chk("glitch_changes", chg_count - c0, 0);

    // Saturation at both ends.
    rst = 1;
    step(2);
    rst = 0;
    c0 = chg_count;
    for (int i = 0; i < 5; i++) begin
      press(1, 0);
      chk("sat_up_idx", speed_idx, up_exp[i]);
    end
    chk("sat_up_changes", chg_count - c0, 3);
    c0 = chg_count;
    for (int i = 0; i < 4; i++) begin
      press(0, 1);
      chk("sat_down_idx", speed_idx, dn_exp[i]);
    end
    chk("sat_down_changes", chg_count - c0, 3);

    // Simultaneous presses at index 2 cancel.
    press(1, 0);
    press(1, 0);
    chk("simul_pre_idx", speed_idx, 2);
    c0 = chg_count;
    press(1, 1);
    chk("simul_idx", speed_idx, 2);
    chk("simul_changes", chg_count - c0, 0);

    // Reset in the middle of a debounce discards the partial count.
    rst = 1;
    step(2);
    rst = 0;
    btn_up = 1;
    step(4);
    rst = 1;
    step(1);
    rst = 0;
    step(7);
    chk("midrst_early_idx", speed_idx, 0);
    step(1);
    chk("midrst_idx", speed_idx, 1);
    btn_up = 0;
    step(12);

    // Random button activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      len = $urandom_range(1, 12);
      btn_up = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      step(len);
    end
    rst = 0;
    btn_up = 0;
    btn_down = 0;
    step(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
